jts16_mapper: RTL and testbench
===============================

JTS16_MAPPER -- requirements
Module: jts16_mapper

Interface
REQ-001 SHALL have parameter REGIONS, default 8, number of mappable regions (1..8).
REQ-002 SHALL have parameter WAITS, default 0, minimum cpu_cen cycles inserted before DTACKn falls.
REQ-003 SHALL have parameter BERR_TO, default 64, cpu_cen cycles without a region hit before bus error.
REQ-004 clk  in  1  system clock; the block has one clock.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 cpu_cen / cpu_cenb  in  1 each  68000 phi1/phi2 clock enables.
REQ-007 A  in  23  CPU address A[23:1].
REQ-008 ASn, RnW, LDSWn  in  1 each  CPU strobes.
REQ-009 din  in  8  CPU write data [7:0].
REQ-010 mapper_cs  in  1  fixed-decode select of the mapper register window.
REQ-011 region_ok  in  REGIONS  per-region data-ready (SDRAM ok or 1 for BRAM).
REQ-012 cs  out  REGIONS  registered one-hot region chip selects.
REQ-013 dout  out  8  register readback.
REQ-014 DTACKn, BERRn  out  1 each  CPU acknowledge / bus error.

Function
REQ-015 SHALL hold 2*REGIONS byte registers: base[n] (A[23:16] match value) at index 2n, size[n][1:0] at 2n+1 (0:64KB,1:128KB,2:512KB,3:1MB masking A[16],A[18:16],A[19:16] respectively; 0 compares A[23:16]).
REQ-016 SHALL write register A[4:1] when mapper_cs && !ASn && !LDSWn, once per bus cycle, on the cpu_cen edge; indices >= 2*REGIONS ignored.
REQ-017 SHALL drive dout with the register at A[4:1] when mapper_cs && RnW, else 8'hff.
REQ-018 SHALL compute hit[n] = (A[23:16] & mask(size[n])) == (base[n] & mask(size[n])) with region enable bit size[n][7].
REQ-019 SHALL register cs one clock after ASn falls; on overlapping hits the lowest index wins; all cs clear one clock after ASn rises.
REQ-020 SHALL never assert cs while mapper_cs is high.
REQ-021 DTACK FSM states IDLE, WAIT, ACK, BERR.
REQ-022 IDLE->WAIT when ASn low; counter loaded with WAITS.
REQ-023 WAIT: counter decrements on cpu_cen; ->ACK on cpu_cen when counter==0 and (mapper_cs or region_ok of active cs).
REQ-024 WAIT->BERR when no cs, no mapper_cs and timeout counter reaches BERR_TO cpu_cen cycles.
REQ-025 ACK drives DTACKn=0, BERR drives BERRn=0; both ->IDLE when ASn high, outputs release same clock.
REQ-026 region_ok dropping while in ACK SHALL not deassert DTACKn.
REQ-027 Timeout counter SHALL saturate, not wrap.

Reset
REQ-028 On rst_n low: cs=0, DTACKn=1, BERRn=1, FSM=IDLE, counters 0, dout=8'hff.
REQ-029 Reset values: base[0]=8'h00, size[0]=8'h83 (enabled, 1MB ROM boot); all other regions base=0, size=0 (disabled).
REQ-030 Reset mid-cycle SHALL abort with no residual register write.

Structure
REQ-031 Size-code encodings, FSM state encoding and reset table SHALL live in shared package jts16_mapper_pkg.
REQ-032 DTACK FSM SHALL be sub-module jts16_mapper_dtack; decode and registers stay in the top.

Verification
REQ-033 After reset read at 0x000100 -> cs[0]=1, DTACKn low after region_ok=1; read index 1 -> dout=8'h83.
REQ-034 Write base[2]=8'h40, size[2]=8'h81 -> access 0x410000 asserts cs[2], 0x420000 asserts none.
REQ-035 Regions 1 and 3 both map 0x84 -> access 0x840000 asserts cs[1] only.
REQ-036 Access unmapped 0xF00000 -> BERRn low after exactly 64 cpu_cen, DTACKn stays high.
REQ-037 WAITS=2, region_ok held low 10 cycles -> DTACKn falls on first cpu_cen after region_ok rises, not before 2 cpu_cen.
REQ-038 Assert rst_n mid-write to mapper -> register retains reset value, outputs at reset values.

Source files
------------

// File: rtl/jts16_mapper_pkg.sv
// Shared definitions for the System 16 address mapper: size codes, DTACK FSM
// states and the register reset table.
package jts16_mapper_pkg;

    typedef enum logic [1:0] {
        SZ_64K  = 2'd0,
        SZ_128K = 2'd1,
        SZ_512K = 2'd2,
        SZ_1M   = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_BERR = 2'd3
    } dtack_st_e;

    localparam int           SIZE_EN_BIT = 7;
    localparam logic [7:0]   RST_BASE0   = 8'h00;
    localparam logic [7:0]   RST_SIZE0   = 8'h83;  // region 0 enabled as 1MB boot ROM

    // Mask applied to A[23:16]: larger regions ignore more low address bits.
    function automatic logic [7:0] size_mask(input logic [1:0] code);
        case (code)
            SZ_64K:  size_mask = 8'hff;
            SZ_128K: size_mask = 8'hfe;
            SZ_512K: size_mask = 8'hf8;
            default: size_mask = 8'hf0;
        endcase
    endfunction

    function automatic logic [7:0] reg_rst(input int idx);
        if (idx == 0)      reg_rst = RST_BASE0;
        else if (idx == 1) reg_rst = RST_SIZE0;
        else               reg_rst = 8'h00;
    endfunction

endpackage

// File: rtl/jts16_mapper_dtack.sv
// 68000 DTACK/BERR handshake: programmable wait states, data-ready gating and
// a saturating bus-error timeout for accesses that hit nothing.
module jts16_mapper_dtack
    import jts16_mapper_pkg::*;
#(
    parameter int WAITS   = 0,
    parameter int BERR_TO = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_cen,
    input  logic i_asn,
    input  logic i_mapper_cs,
    input  logic i_cs_any,
    input  logic i_ok,
    output logic o_dtackn,
    output logic o_berrn
);
    localparam int WW = (WAITS > 0) ? $clog2(WAITS + 1) : 1;
    localparam int TW = $clog2(BERR_TO + 1);

    dtack_st_e       r_st;
    logic [WW-1:0]   r_wcnt;
    logic [TW-1:0]   r_tcnt;
    logic            r_dtackn;
    logic            r_berrn;
    logic [TW-1:0]   w_tnext;

    assign w_tnext  = (r_tcnt == TW'(BERR_TO)) ? r_tcnt : r_tcnt + TW'(1);
    assign o_dtackn = r_dtackn;
    assign o_berrn  = r_berrn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st     <= ST_IDLE;
            r_wcnt   <= '0;
            r_tcnt   <= '0;
            r_dtackn <= 1'b1;
            r_berrn  <= 1'b1;
        end else begin
            case (r_st)
                ST_IDLE: if (!i_asn) begin
                    r_st   <= ST_WAIT;
                    r_wcnt <= WW'(WAITS);
                    r_tcnt <= '0;
                end
                ST_WAIT: begin
                    if (i_asn) begin
                        r_st <= ST_IDLE;
                    end else if (i_cen) begin
                        if (r_wcnt != '0) r_wcnt <= r_wcnt - WW'(1);
                        if (r_wcnt == '0 && (i_mapper_cs || i_ok)) begin
                            r_st     <= ST_ACK;
                            r_dtackn <= 1'b0;
                        end else if (!i_cs_any && !i_mapper_cs) begin
                            r_tcnt <= w_tnext;
                            if (w_tnext == TW'(BERR_TO)) begin
                                r_st    <= ST_BERR;
                                r_berrn <= 1'b0;
                            end
                        end
                    end
                end
                // Once acknowledged, only the end of the bus cycle releases.
                ST_ACK, ST_BERR: if (i_asn) begin
                    r_st     <= ST_IDLE;
                    r_dtackn <= 1'b1;
                    r_berrn  <= 1'b1;
                end
                default: r_st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/jts16_mapper.sv
// Programmable region decoder: base/size byte registers, one-hot chip selects
// with lowest-index priority, register readback and the DTACK handshake.
module jts16_mapper
    import jts16_mapper_pkg::*;
#(
    parameter int REGIONS = 8,
    parameter int WAITS   = 0,
    parameter int BERR_TO = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_cen,
    input  logic               cpu_cenb,
    input  logic [23:1]        A,
    input  logic               ASn,
    input  logic               RnW,
    input  logic               LDSWn,
    input  logic [7:0]         din,
    input  logic               mapper_cs,
    input  logic [REGIONS-1:0] region_ok,
    output logic [REGIONS-1:0] cs,
    output logic [7:0]         dout,
    output logic               DTACKn,
    output logic               BERRn
);
    localparam int NREG = 2 * REGIONS;

    logic [NREG-1:0][7:0]  r_regs;
    logic                  r_wr_done;
    logic [7:0]            r_dout;
    logic [REGIONS-1:0]    r_cs;
    logic [3:0]            w_idx;
    logic                  w_wr;
    logic [7:0]            w_rd;
    logic [REGIONS-1:0]    w_hit;
    logic [REGIONS-1:0]    w_sel;
    logic                  w_unused;

    assign w_idx    = A[4:1];
    assign w_unused = ^{cpu_cenb, A[15:5]};
    // Data strobes are low on reads as well, so RnW gates the write.
    assign w_wr     = mapper_cs && !ASn && !LDSWn && !RnW && !r_wr_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= reg_rst(i);
            r_wr_done <= 1'b0;
        end else if (ASn) begin
            r_wr_done <= 1'b0;
        end else if (w_wr && cpu_cen) begin
            r_wr_done <= 1'b1;
            for (int i = 0; i < NREG; i++)
                if (w_idx == 4'(i)) r_regs[i] <= din;
        end
    end

    always_comb begin
        w_rd = 8'hff;
        for (int i = 0; i < NREG; i++)
            if (w_idx == 4'(i)) w_rd = r_regs[i];
    end

    always_comb begin
        w_hit = '0;
        for (int n = 0; n < REGIONS; n++)
            w_hit[n] = r_regs[2*n+1][SIZE_EN_BIT] &&
                ((A[23:16] & size_mask(r_regs[2*n+1][1:0])) ==
                 (r_regs[2*n] & size_mask(r_regs[2*n+1][1:0])));
    end

    // Isolate the lowest set bit so overlapping regions resolve to one select.
    assign w_sel = w_hit & (~w_hit + REGIONS'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs   <= '0;
            r_dout <= 8'hff;
        end else begin
            r_cs   <= (!ASn && !mapper_cs) ? w_sel : '0;
            r_dout <= (mapper_cs && RnW) ? w_rd : 8'hff;
        end
    end

    assign cs   = r_cs;
    assign dout = r_dout;

    jts16_mapper_dtack #(
        .WAITS   (WAITS),
        .BERR_TO (BERR_TO)
    ) u_dtack (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cen       (cpu_cen),
        .i_asn       (ASn),
        .i_mapper_cs (mapper_cs),
        .i_cs_any    (|r_cs),
        .i_ok        (|(r_cs & region_ok)),
        .o_dtackn    (DTACKn),
        .o_berrn     (BERRn)
    );

endmodule

// File: tb/tb_jts16_mapper.sv
// Bench for jts16_mapper: register access, region decode vectors with a cs
// scoreboard, bus-error timeout, wait states and reset during a write.
module tb_jts16_mapper;
    localparam int R = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_cen = 1'b0;
    logic          cpu_cenb = 1'b0;
    logic [23:1]   A = '0;
    logic          ASn = 1'b1;
    logic          RnW = 1'b1;
    logic          LDSWn = 1'b1;
    logic [7:0]    din = 8'h00;
    logic          mapper_cs = 1'b0;
    logic [R-1:0]  region_ok = '1;
    logic [R-1:0]  cs, cs_w;
    logic [7:0]    dout, dout_w;
    logic          dtackn, berrn, dtackn_w, berrn_w;

    int            n_chk = 0;
    int            n_pass = 0;
    logic [R-1:0]  exp_q[$];

    typedef struct {
        logic [23:0]  addr;
        logic [R-1:0] ok;
        logic [R-1:0] exp_cs;
        logic         exp_dtackn;
    } vec_t;
    vec_t vecs[12];

    always #5 clk = ~clk;

    jts16_mapper dut (
        .clk(clk), .rst_n(rst_n), .cpu_cen(cpu_cen), .cpu_cenb(cpu_cenb),
        .A(A), .ASn(ASn), .RnW(RnW), .LDSWn(LDSWn), .din(din),
        .mapper_cs(mapper_cs), .region_ok(region_ok),
        .cs(cs), .dout(dout), .DTACKn(dtackn), .BERRn(berrn)
    );

    jts16_mapper #(.WAITS(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .cpu_cen(cpu_cen), .cpu_cenb(cpu_cenb),
        .A(A), .ASn(ASn), .RnW(RnW), .LDSWn(LDSWn), .din(din),
        .mapper_cs(mapper_cs), .region_ok(region_ok),
        .cs(cs_w), .dout(dout_w), .DTACKn(dtackn_w), .BERRn(berrn_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic cen;
        cpu_cen = 1'b1;
        @(negedge clk);
        cpu_cen = 1'b0;
    endtask

    task automatic idle_bus;
        ASn = 1'b1; mapper_cs = 1'b0; RnW = 1'b1; LDSWn = 1'b1;
    endtask

    task automatic write_reg(input logic [3:0] idx, input logic [7:0] val);
        A = 23'(idx); mapper_cs = 1'b1; RnW = 1'b0; LDSWn = 1'b0; din = val; ASn = 1'b0;
        tick; cen; tick;
        idle_bus; tick;
    endtask

    task automatic read_reg(input logic [3:0] idx, input logic [7:0] exp, input string name);
        A = 23'(idx); mapper_cs = 1'b1; RnW = 1'b1; LDSWn = 1'b0; ASn = 1'b0;
        tick; tick;
        check(name, dout, exp);
        check({name, "_no_cs"}, cs, '0);
        idle_bus; tick; tick;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{24'h000100, 8'hff, 8'h01, 1'b0};
        vecs[1]  = '{24'h0ffffe, 8'hff, 8'h01, 1'b0};
        vecs[2]  = '{24'h100000, 8'hff, 8'h00, 1'b1};
        vecs[3]  = '{24'h410000, 8'hff, 8'h04, 1'b0};
        vecs[4]  = '{24'h400000, 8'hff, 8'h04, 1'b0};
        vecs[5]  = '{24'h420000, 8'hff, 8'h00, 1'b1};
        vecs[6]  = '{24'h840000, 8'hff, 8'h02, 1'b0};
        vecs[7]  = '{24'h84fffe, 8'hff, 8'h02, 1'b0};
        vecs[8]  = '{24'h850000, 8'hff, 8'h00, 1'b1};
        vecs[9]  = '{24'h000100, 8'hfe, 8'h01, 1'b1};
        vecs[10] = '{24'h840000, 8'hfd, 8'h02, 1'b1};
        vecs[11] = '{24'h000000, 8'h01, 8'h01, 1'b0};

        // Reset state
        tick; tick;
        check("rst_cs", cs, '0);
        check("rst_dtackn", dtackn, 1'b1);
        check("rst_berrn", berrn, 1'b1);
        check("rst_dout", dout, 8'hff);
        rst_n = 1'b1;
        tick;

        read_reg(4'd1, 8'h83, "rd_size0");
        read_reg(4'd0, 8'h00, "rd_base0");
        read_reg(4'd3, 8'h00, "rd_size1");

        write_reg(4'd4, 8'h40);
        write_reg(4'd5, 8'h81);
        write_reg(4'd2, 8'h84);
        write_reg(4'd3, 8'h80);
        write_reg(4'd6, 8'h84);
        write_reg(4'd7, 8'h80);
        read_reg(4'd5, 8'h81, "rd_size2");
        read_reg(4'd2, 8'h84, "rd_base1");

        // Second cpu_cen within the same bus cycle must not write again
        A = 23'(8); mapper_cs = 1'b1; RnW = 1'b0; LDSWn = 1'b0; din = 8'h11; ASn = 1'b0;
        tick; cen;
        din = 8'h22; cen;
        idle_bus; tick;
        read_reg(4'd8, 8'h11, "wr_once");

        foreach (vecs[i]) begin
            A = vecs[i].addr[23:1]; region_ok = vecs[i].ok; RnW = 1'b1; ASn = 1'b0;
            exp_q.push_back(vecs[i].exp_cs);
            tick;
            check($sformatf("cs_vec%0d", i), cs, exp_q.pop_front());
            cen;
            check($sformatf("dtackn_vec%0d", i), dtackn, vecs[i].exp_dtackn);
            ASn = 1'b1;
            tick;
            check($sformatf("release_vec%0d", i), {cs, dtackn}, {8'h00, 1'b1});
        end
        region_ok = '1;

        // region_ok dropping during ACK keeps DTACKn low
        A = 23'h000080; ASn = 1'b0;
        tick; cen;
        check("ack_hold_pre", dtackn, 1'b0);
        region_ok = '0;
        tick; tick;
        check("ack_hold", dtackn, 1'b0);
        ASn = 1'b1;
        tick;
        check("ack_release", dtackn, 1'b1);
        region_ok = '1;

        // Unmapped access: bus error on exactly the 64th cpu_cen
        A = 23'h780000; ASn = 1'b0;
        tick; tick;
        for (int k = 1; k <= 64; k++) begin
            cen;
            check($sformatf("berrn_cen%0d", k), berrn, (k == 64) ? 1'b0 : 1'b1);
        end
        check("berr_no_dtack", dtackn, 1'b1);
        ASn = 1'b1;
        tick;
        check("berr_release", berrn, 1'b1);

        // WAITS=2 instance: data not ready for 10 cpu_cen, then ready
        A = 23'h000080; region_ok = '0; ASn = 1'b0;
        tick; tick;
        for (int k = 0; k < 10; k++) begin
            cen;
            check($sformatf("wait_notok%0d", k), dtackn_w, 1'b1);
        end
        region_ok = '1;
        cen;
        check("wait_ok_ack", dtackn_w, 1'b0);
        ASn = 1'b1;
        tick; tick;
        ASn = 1'b0;
        tick;
        cen;
        check("wait_min1", dtackn_w, 1'b1);
        cen;
        check("wait_min2", dtackn_w, 1'b1);
        cen;
        check("wait_min_ack", dtackn_w, 1'b0);
        ASn = 1'b1;
        tick;
        check("wait_release", dtackn_w, 1'b1);
        tick;

        // Reset during a register write
        A = 23'(1); mapper_cs = 1'b1; RnW = 1'b0; LDSWn = 1'b0; din = 8'h00; ASn = 1'b0;
        tick;
        rst_n = 1'b0;
        cen;
        check("midrst_cs", cs, '0);
        check("midrst_dtackn", dtackn, 1'b1);
        check("midrst_berrn", berrn, 1'b1);
        check("midrst_dout", dout, 8'hff);
        idle_bus;
        tick;
        rst_n = 1'b1;
        tick;
        read_reg(4'd1, 8'h83, "midrst_size0");
        read_reg(4'd5, 8'h00, "midrst_size2");
        read_reg(4'd4, 8'h00, "midrst_base2");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
